// File: rtl/mm_tile_sched_pkg.sv
// Shared types and lane helpers for the blocked 2x2 tile matrix-multiply scheduler.
package mm_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, MAC, WRITE, DONE} state_t;

   // Lane positions inside a packed tile {X22,X21,X12,X11}
   localparam int L11 = 0;
   localparam int L12 = 1;
   localparam int L21 = 2;
   localparam int L22 = 3;

   // Widest element the helpers can unpack; callers zero-extend into this
   localparam int MAXW = 32;

   // Element l of a packed tile whose elements are w bits wide
   function automatic logic [MAXW-1:0] tile_lane(input logic [4*MAXW-1:0] vec,
                                                 input int l, input int w);
      tile_lane = MAXW'(vec >> (l*w)) & ({MAXW{1'b1}} >> (MAXW - w));
   endfunction

   // Product lane l of a multiplier result whose lanes are 2*w bits wide
   function automatic logic [2*MAXW-1:0] prod_lane(input logic [8*MAXW-1:0] vec,
                                                   input int l, input int w);
      prod_lane = (2*MAXW)'(vec >> (l*2*w)) & ({(2*MAXW){1'b1}} >> (2*MAXW - 2*w));
   endfunction

endpackage

// File: rtl/mm_tile_sched_if.sv
// Operand read, multiplier and result write signals of the tile scheduler.
interface mm_tile_sched_if #(
   parameter int WIDTH = 16,
   parameter int N     = 4
);
   localparam int T  = N / 2;
   localparam int TW = (T > 1) ? $clog2(T) : 1;

   logic                 a_rd_en;
   logic [TW-1:0]        a_rd_row;
   logic [TW-1:0]        a_rd_col;
   logic [4*WIDTH-1:0]   a_rd_data;
   logic                 b_rd_en;
   logic [TW-1:0]        b_rd_row;
   logic [TW-1:0]        b_rd_col;
   logic [4*WIDTH-1:0]   b_rd_data;
   logic [4*WIDTH-1:0]   eng_a;
   logic [4*WIDTH-1:0]   eng_b;
   logic [8*WIDTH-1:0]   eng_c;
   logic                 c_wr_en;
   logic                 c_wr_ready;
   logic [TW-1:0]        c_wr_row;
   logic [TW-1:0]        c_wr_col;
   logic [4*WIDTH-1:0]   c_wr_data;

   modport master (
      output a_rd_en, a_rd_row, a_rd_col,
      output b_rd_en, b_rd_row, b_rd_col,
      output eng_a, eng_b,
      output c_wr_en, c_wr_row, c_wr_col, c_wr_data,
      input  a_rd_data, b_rd_data, eng_c, c_wr_ready
   );

   modport slave (
      input  a_rd_en, a_rd_row, a_rd_col,
      input  b_rd_en, b_rd_row, b_rd_col,
      input  eng_a, eng_b,
      input  c_wr_en, c_wr_row, c_wr_col, c_wr_data,
      output a_rd_data, b_rd_data, eng_c, c_wr_ready
   );
endinterface

// File: rtl/mm_tile_acc.sv
// Four-lane modulo-2^WIDTH accumulator fed by the low half of each product lane.
module mm_tile_acc
   import mm_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [8*WIDTH-1:0] prod,
   output logic [4*WIDTH-1:0] acc
);
   logic [8*MAXW-1:0] prod_x;

   assign prod_x = (8*MAXW)'(prod);

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] q;

      assign p = WIDTH'(prod_lane(prod_x, l, WIDTH));
      assign acc[l*WIDTH +: WIDTH] = q;

      // lane register: clear wins over accumulate, wrap is intentional
      always_ff @(posedge clk or posedge rst) begin
         if (rst)      q <= '0;
         else if (clr) q <= '0;
         else if (en)  q <= q + p;
      end
   end
endmodule

// File: rtl/mm_tile_sched.sv
// Walks C(i,j) tiles row-major, accumulating A(i,k)*B(k,j) over k through one
// shared combinational 2x2 multiplier, and writes each finished tile once.
module mm_tile_sched
   import mm_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int N     = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic abort,
   output logic busy,
   output logic done,
   mm_tile_sched_if.master bus
);
   localparam int T  = N / 2;
   localparam int TW = (T > 1) ? $clog2(T) : 1;
   localparam logic [TW-1:0] LAST = TW'(T - 1);

   state_t             state, nxt;
   logic [TW-1:0]      i, j, k;
   logic [4*WIDTH-1:0] eng_a_q, eng_b_q, acc;
   logic               go, last_k, last_j, last_i;
   logic               wr_en, xfer, acc_clr, acc_en;

   assign go      = start & ~abort;
   assign last_k  = (k == LAST);
   assign last_j  = (j == LAST);
   assign last_i  = (i == LAST);
   // an abort in WRITE drops the pending tile, so the strobe is withdrawn
   assign wr_en   = (state == WRITE) & ~abort;
   assign xfer    = wr_en & bus.c_wr_ready;
   assign acc_clr = ((state == IDLE) & go) | xfer;
   assign acc_en  = (state == MAC) & ~abort;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // next state and output decode
   always_comb begin
      nxt           = state;
      busy          = (state != IDLE);
      done          = (state == DONE);
      bus.a_rd_en   = 1'b0;
      bus.a_rd_row  = '0;
      bus.a_rd_col  = '0;
      bus.b_rd_en   = 1'b0;
      bus.b_rd_row  = '0;
      bus.b_rd_col  = '0;
      bus.eng_a     = eng_a_q;
      bus.eng_b     = eng_b_q;
      bus.c_wr_en   = wr_en;
      bus.c_wr_row  = '0;
      bus.c_wr_col  = '0;
      bus.c_wr_data = '0;
      if (state == FETCH) begin
         bus.a_rd_en  = 1'b1;
         bus.a_rd_row = i;
         bus.a_rd_col = k;
         bus.b_rd_en  = 1'b1;
         bus.b_rd_row = k;
         bus.b_rd_col = j;
      end
      if (wr_en) begin
         bus.c_wr_row  = i;
         bus.c_wr_col  = j;
         bus.c_wr_data = acc;
      end
      if (state != IDLE && abort) begin
         nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (go) nxt = FETCH;
            FETCH:   nxt = LOAD;
            LOAD:    nxt = MAC;
            MAC:     nxt = last_k ? WRITE : FETCH;
            WRITE:   if (xfer) nxt = (last_i && last_j) ? DONE : FETCH;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   // tile indices: k steps inside a tile, (i,j) advance row-major on each write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (state == IDLE) begin
         if (go) begin
            i <= '0;
            j <= '0;
            k <= '0;
         end
      end else if (!abort) begin
         if (state == MAC && !last_k) k <= k + 1'b1;
         if (xfer) begin
            k <= '0;
            j <= last_j ? '0 : j + 1'b1;
            if (last_j) i <= last_i ? '0 : i + 1'b1;
         end
      end
   end

   // operand registers feeding the multiplier, loaded the cycle after the read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_a_q <= '0;
         eng_b_q <= '0;
      end else if (state == LOAD && !abort) begin
         eng_a_q <= bus.a_rd_data;
         eng_b_q <= bus.b_rd_data;
      end
   end

   mm_tile_acc #(.WIDTH(WIDTH)) u_acc (
      .clk  (clk),
      .rst  (rst),
      .clr  (acc_clr),
      .en   (acc_en),
      .prod (bus.eng_c),
      .acc  (acc)
   );
endmodule
